if_pc_gen: RTL and testbench
============================

Name: if_pc_gen

Overview:
Fetch-side PC generator and fetch-request initiator for the pipelined core. It issues instruction fetch requests to instruction memory and captures responses. It mini-decodes each returned instruction to predict the next PC (JAL, JALR, static backward-taken branches) and hands instruction/PC/prediction to ID. It instantiates `if_mini_dec` internally on the captured instruction and accepts EX-stage redirects.

Parameters:
XLEN, 64, datapath/PC width.
RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
ifu_req_valid_o  out  1  fetch request valid.
ifu_req_ready_i  in  1  memory accepts request.
ifu_req_pc_o  out  XLEN  fetch address.
ifu_rsp_valid_i  in  1  fetch response valid (always accepted).
ifu_rsp_instr_i  in  32  fetched instruction.
pc_gen_rs1_idx_o  out  5  regfile read index for JALR base.
rf_rs1_rdata_i  in  XLEN  regfile read data (combinational).
rs1_busy_i  in  1  in-flight write pending to rs1 (scoreboard).
if_valid_o  out  1  instruction valid to ID.
if_instr_o  out  32  instruction to ID.
if_pc_o  out  XLEN  PC of if_instr_o.
if_pred_taken_o  out  1  next PC predicted non-sequential.
if_pred_pc_o  out  XLEN  predicted next PC.
id_ready_i  in  1  ID accepts instruction.
ex_flush_i  in  1  redirect from EX (mispredict or trap).
ex_flush_pc_i  in  XLEN  redirect target.

Behaviour:
- Reset (async, rst_n=0): state=BOOT, pc_q=RESET_PC, ifu_req_valid_o=0, if_valid_o=0, if_instr_o=0, if_pc_o=0, if_pred_taken_o=0, if_pred_pc_o=0, kill_q=0. Reset mid-transaction drops everything; an outstanding response after reset release is not expected (memory is reset together).
- FSM states: BOOT, REQ, WAIT, HOLD, JWAIT.
- BOOT: unconditionally -> REQ in the first cycle after reset release.
- REQ: ifu_req_valid_o=1, ifu_req_pc_o=pc_q. On ifu_req_ready_i -> WAIT. Valid stays high and the PC stays stable until ready. Single outstanding request only.
- WAIT: on ifu_rsp_valid_i with kill_q=0, capture the instruction and PC into the output regs and compute the prediction from mini-decode of the captured instruction:
  - JAL: target = pc + imm, taken=1.
  - BRANCH: taken = imm[XLEN-1] (backward). Target = pc + imm if taken, else pc + 4.
  - JALR: if rs1_busy_i, go to JWAIT. Otherwise target = (rf_rs1_rdata_i + imm) & ~1, taken=1. rs1 index = 0 gives target = imm & ~1.
  - Other instructions: pc + 4, taken=0.
  - Then if_valid_o=1, pc_q=target, and go to HOLD (or JWAIT).
- Sums wrap modulo 2^XLEN. Immediates are sign-extended by the mini decoder.
- JWAIT: if_valid_o=0. pc_gen_rs1_idx_o holds the captured rs1. When rs1_busy_i drops, compute the JALR target that cycle, set if_valid_o=1, and go to HOLD.
- HOLD: if_valid_o=1 with all if_* outputs stable. On id_ready_i: if_valid_o=0 next cycle and go to REQ with pc_q. A new request is therefore issued the cycle after ID acceptance. Minimum throughput is 1 instruction per 3 cycles with zero-wait memory.
- ex_flush_i has highest priority in every state:
  - pc_q = ex_flush_pc_i; if_valid_o cleared next cycle; next state REQ.
  - If flushed in WAIT (response not yet seen), set kill_q=1 and next state WAIT. The next ifu_rsp_valid_i is discarded and clears kill_q, then the FSM goes to REQ.
  - Flush in REQ while ready is high in the same cycle counts as an accepted request: kill_q=1 and next state WAIT.
  - Flush coinciding with ifu_rsp_valid_i in WAIT: the response is dropped, kill_q stays 0, and the next state is REQ.
- The flush PC is used as-is; no alignment check (EX handles misaligned traps).
- Response arriving in any state other than WAIT is a protocol violation. The block ignores it; the bench flags it as an error.

Test Plan:
- Reset release, ready=1, zero-wait memory -> first request pc=0x8000_0000 one cycle after rst_n rises. Instr ADDI (0x00000013) -> if_pc_o=0x8000_0000, pred_taken=0, pred_pc=0x8000_0004; next request 0x8000_0004.
- JAL imm=+0x10 at 0x8000_0000 -> pred_taken=1, pred_pc=0x8000_0010, next request at 0x8000_0010. Branch imm=-8 at 0x8000_0010 -> taken, 0x8000_0008. Branch imm=+8 -> not taken, 0x8000_0014.
- JALR rs1=x5, imm=3, rs1_busy_i=1 for 4 cycles, then rdata=0x8000_1000 -> if_valid_o low for those 4 cycles, then pred_pc=0x8000_1002 (bit0 cleared).
- ifu_req_ready_i low for 5 cycles -> ifu_req_valid_o held high with PC constant, no response consumed.
- ex_flush_i to 0x8000_2000 while in WAIT, response 2 cycles later -> that response not presented to ID; next request pc=0x8000_2000.
- id_ready_i low 3 cycles in HOLD with flush in the 2nd -> if_valid_o drops, next request 0x8000_2000, held instruction never accepted; async reset asserted mid-WAIT -> all outputs zero immediately.

Source files
------------

// File: rtl/if_pc_gen.sv
// -----------------------------------------------------------------------------
// if_pc_gen -- fetch-side PC generator and fetch-request initiator.
//
// Issues one instruction fetch at a time, captures the response, predicts the
// next PC from a mini-decode of the captured instruction (JAL, JALR, static
// backward-taken branches) and presents instruction/PC/prediction to ID.
// EX-stage redirects override everything.
//
// Handshake semantics (all interfaces):
//   A transfer happens on a rising edge where valid and ready are both high.
//   Once valid is raised it stays high with its payload stable until that
//   transfer, unless an EX redirect (ex_flush_i) withdraws it. ifu_rsp_valid_i
//   has no ready: a response is always consumed on the edge it is valid.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   ifu_req_valid_o/ready_i    fetch request handshake
//   ifu_req_pc_o               fetch address
//   ifu_rsp_valid_i/instr_i    fetch response (always accepted)
//   pc_gen_rs1_idx_o           regfile read index for a JALR base
//   rf_rs1_rdata_i             regfile read data (combinational)
//   rs1_busy_i                 write pending to the JALR base register
//   if_valid_o/id_ready_i      instruction handshake towards ID
//   if_instr_o, if_pc_o        instruction and its PC
//   if_pred_taken_o/pred_pc_o  prediction for the next PC
//   ex_flush_i, ex_flush_pc_i  redirect from EX and its target
//   dbg_state                  current FSM state (debug visibility)
// -----------------------------------------------------------------------------

// Mini decoder: classifies control-flow instructions and extracts the
// sign-extended immediate and rs1 field needed for next-PC prediction.
module if_mini_dec #(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_branch,
  output logic [4:0]      rs1,
  output logic [XLEN-1:0] imm
);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0] opcode;

  assign opcode    = instr[6:0];
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);
  assign rs1       = instr[19:15];

  always_comb begin
    imm = '0;
    if (is_jal) begin
      // J-type: imm[20|10:1|11|19:12]
      imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    end else if (is_branch) begin
      // B-type: imm[12|10:5] ... imm[4:1|11]
      imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    end else if (is_jalr) begin
      // I-type: imm[11:0]
      imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
    end
  end
endmodule

module if_pc_gen #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ifu_req_valid_o,
  input  logic            ifu_req_ready_i,
  output logic [XLEN-1:0] ifu_req_pc_o,
  input  logic            ifu_rsp_valid_i,
  input  logic [31:0]     ifu_rsp_instr_i,
  output logic [4:0]      pc_gen_rs1_idx_o,
  input  logic [XLEN-1:0] rf_rs1_rdata_i,
  input  logic            rs1_busy_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            if_pred_taken_o,
  output logic [XLEN-1:0] if_pred_pc_o,
  input  logic            id_ready_i,
  input  logic            ex_flush_i,
  input  logic [XLEN-1:0] ex_flush_pc_i,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    JWAIT = 3'd4
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  // Set when the outstanding fetch was redirected away: its response is junk.
  logic            kill_q;

  // Decode source: in WAIT the incoming response is decoded directly so the
  // prediction is registered together with the instruction. In JWAIT the
  // captured instruction is decoded again to finish the deferred JALR.
  logic            in_wait;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic            dec_is_jal;
  logic            dec_is_jalr;
  logic            dec_is_branch;
  logic [4:0]      dec_rs1;
  logic [XLEN-1:0] dec_imm;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] jalr_base;
  logic [XLEN-1:0] jalr_tgt;
  logic            pred_taken;
  logic [XLEN-1:0] pred_pc;

  assign in_wait   = (state == WAIT);
  assign dec_instr = in_wait ? ifu_rsp_instr_i : if_instr_o;
  assign dec_pc    = in_wait ? pc_q : if_pc_o;

  if_mini_dec #(
    .XLEN (XLEN)
  ) u_mini_dec (
    .instr     (dec_instr),
    .is_jal    (dec_is_jal),
    .is_jalr   (dec_is_jalr),
    .is_branch (dec_is_branch),
    .rs1       (dec_rs1),
    .imm       (dec_imm)
  );

  // x0 always reads as zero regardless of what the regfile port returns.
  assign jalr_base = (dec_rs1 == 5'd0) ? '0 : rf_rs1_rdata_i;
  assign jalr_tgt  = (jalr_base + dec_imm) & ~(XLEN'(1));
  assign seq_pc    = dec_pc + XLEN'(4);
  assign rel_pc    = dec_pc + dec_imm;

  // Static prediction: jumps always taken, branches taken only when the
  // offset is negative (loop back-edges), everything else falls through.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = seq_pc;
    if (dec_is_jal) begin
      pred_taken = 1'b1;
      pred_pc    = rel_pc;
    end else if (dec_is_branch) begin
      pred_taken = dec_imm[XLEN-1];
      pred_pc    = dec_imm[XLEN-1] ? rel_pc : seq_pc;
    end else if (dec_is_jalr) begin
      pred_taken = 1'b1;
      pred_pc    = jalr_tgt;
    end
  end

  assign ifu_req_pc_o     = pc_q;
  assign pc_gen_rs1_idx_o = dec_rs1;
  assign dbg_state        = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= BOOT;
      pc_q            <= RESET_PC;
      kill_q          <= 1'b0;
      ifu_req_valid_o <= 1'b0;
      if_valid_o      <= 1'b0;
      if_instr_o      <= '0;
      if_pc_o         <= '0;
      if_pred_taken_o <= 1'b0;
      if_pred_pc_o    <= '0;
    end else if (ex_flush_i) begin
      // Redirect wins in every state. What matters is whether a fetch is
      // still in flight afterwards: if so, wait for and discard it.
      pc_q       <= ex_flush_pc_i;
      if_valid_o <= 1'b0;
      case (state)
        REQ: begin
          if (ifu_req_ready_i) begin
            // The request was accepted this very edge: it is now in flight.
            state           <= WAIT;
            kill_q          <= 1'b1;
            ifu_req_valid_o <= 1'b0;
          end else begin
            state           <= REQ;
            ifu_req_valid_o <= 1'b1;
          end
        end
        WAIT: begin
          if (ifu_rsp_valid_i) begin
            // Response lands on the flush edge: drop it, nothing in flight.
            state           <= REQ;
            kill_q          <= 1'b0;
            ifu_req_valid_o <= 1'b1;
          end else begin
            state           <= WAIT;
            kill_q          <= 1'b1;
            ifu_req_valid_o <= 1'b0;
          end
        end
        default: begin
          state           <= REQ;
          ifu_req_valid_o <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        BOOT: begin
          state           <= REQ;
          ifu_req_valid_o <= 1'b1;
        end
        REQ: begin
          if (ifu_req_ready_i) begin
            state           <= WAIT;
            ifu_req_valid_o <= 1'b0;
          end
        end
        WAIT: begin
          if (ifu_rsp_valid_i) begin
            if (kill_q) begin
              kill_q          <= 1'b0;
              state           <= REQ;
              ifu_req_valid_o <= 1'b1;
            end else begin
              if_instr_o <= ifu_rsp_instr_i;
              if_pc_o    <= pc_q;
              if (dec_is_jalr && rs1_busy_i) begin
                // Base register not yet written back: finish in JWAIT.
                state <= JWAIT;
              end else begin
                if_valid_o      <= 1'b1;
                if_pred_taken_o <= pred_taken;
                if_pred_pc_o    <= pred_pc;
                pc_q            <= pred_pc;
                state           <= HOLD;
              end
            end
          end
        end
        JWAIT: begin
          if (!rs1_busy_i) begin
            if_valid_o      <= 1'b1;
            if_pred_taken_o <= pred_taken;
            if_pred_pc_o    <= pred_pc;
            pc_q            <= pred_pc;
            state           <= HOLD;
          end
        end
        HOLD: begin
          if (id_ready_i) begin
            if_valid_o      <= 1'b0;
            state           <= REQ;
            ifu_req_valid_o <= 1'b1;
          end
        end
        default: begin
          state           <= BOOT;
          ifu_req_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_if_pc_gen -- randomized self-checking bench for if_pc_gen.
// A memory model answers fetches, a regfile model serves JALR bases, and a
// transaction-level reference model tracks which PC must be fetched next and
// what ID must see for each fetched instruction.
// -----------------------------------------------------------------------------
module tb_if_pc_gen;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [63:0] JALR_PC  = 64'h8000_000C;

  // ---------------------------------------------------------------- clock/reset
  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_pc;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_instr;
  logic [4:0]  rs1_idx;
  logic [63:0] rs1_rdata;
  logic        rs1_busy;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_pred_taken;
  logic [63:0] if_pred_pc;
  logic        id_ready;
  logic        ex_flush;
  logic [63:0] ex_flush_pc;
  logic [2:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_pc_gen #(
    .XLEN     (64),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ifu_req_valid_o  (ifu_req_valid),
    .ifu_req_ready_i  (ifu_req_ready),
    .ifu_req_pc_o     (ifu_req_pc),
    .ifu_rsp_valid_i  (ifu_rsp_valid),
    .ifu_rsp_instr_i  (ifu_rsp_instr),
    .pc_gen_rs1_idx_o (rs1_idx),
    .rf_rs1_rdata_i   (rs1_rdata),
    .rs1_busy_i       (rs1_busy),
    .if_valid_o       (if_valid),
    .if_instr_o       (if_instr),
    .if_pc_o          (if_pc),
    .if_pred_taken_o  (if_pred_taken),
    .if_pred_pc_o     (if_pred_pc),
    .id_ready_i       (id_ready),
    .ex_flush_i       (ex_flush),
    .ex_flush_pc_i    (ex_flush_pc),
    .dbg_state        (dbg_state)
  );

  // ---------------------------------------------------------------- models
  // kind: 0 other, 1 JAL, 2 BRANCH, 3 JALR
  typedef struct {
    logic [31:0] instr;
    int          kind;
    longint      imm;
    int          rs1;
  } ent_t;

  ent_t        mem[logic [63:0]];
  logic [63:0] rf[32];
  assign rs1_rdata = rf[rs1_idx];

  logic [63:0] exp_q[$];   // expected fetch addresses, in order
  logic        exp_valid;
  logic        outstanding;
  logic        killed;
  logic [63:0] out_addr;
  logic [63:0] out_pc;
  int          rsp_delay;
  logic        inst_pending;
  logic [63:0] pend_pc;
  logic        jalr_pend;
  int          busy_left;
  int          jalr_rs1;
  logic [63:0] jalr_new;
  logic        hold_chk;
  logic [63:0] hold_pc;
  int          n_id_acc;
  int          n_checks;
  int          n_pass;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_j(input longint imm);
    logic [20:0] v;
    v = imm[20:0];
    return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input longint imm);
    logic [12:0] v;
    v = imm[12:0];
    return {v[12], v[10:5], 5'd2, 5'd3, 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input longint imm, input int rs1);
    logic [11:0] v;
    logic [4:0]  r;
    v = imm[11:0];
    r = rs1[4:0];
    return {v, r, 3'b000, 5'd1, 7'b1100111};
  endfunction

  function automatic ent_t make_ent();
    ent_t        e;
    int          sel;
    logic [31:0] r;
    logic [6:0]  op;
    sel   = $urandom_range(0, 9);
    e.imm = 0;
    e.rs1 = 0;
    if (sel < 5) begin
      r = $urandom();
      case ($urandom_range(0, 5))
        0: op = 7'b0010011;
        1: op = 7'b0110011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: op = 7'b0110111;
        default: op = 7'b0010111;
      endcase
      e.kind  = 0;
      e.instr = {r[31:7], op};
    end else if (sel < 7) begin
      e.kind  = 1;
      e.imm   = (longint'($urandom_range(0, 2047)) - 1024) * 2;
      e.instr = enc_j(e.imm);
    end else if (sel < 9) begin
      e.kind  = 2;
      e.imm   = (longint'($urandom_range(0, 4095)) - 2048) * 2;
      e.instr = enc_b(e.imm);
    end else begin
      e.kind  = 3;
      e.rs1   = $urandom_range(0, 31);
      e.imm   = longint'($urandom_range(0, 4095)) - 2048;
      e.instr = enc_jalr(e.imm, e.rs1);
    end
    return e;
  endfunction

  task automatic ensure_ent(input logic [63:0] a);
    if (!mem.exists(a)) mem[a] = make_ent();
  endtask

  task automatic put_ent(input logic [63:0] a, input int kind, input longint imm, input int rs1);
    ent_t e;
    e.kind = kind;
    e.imm  = imm;
    e.rs1  = rs1;
    case (kind)
      1: e.instr = enc_j(imm);
      2: e.instr = enc_b(imm);
      3: e.instr = enc_jalr(imm, rs1);
      default: e.instr = 32'h0000_0013;
    endcase
    mem[a] = e;
  endtask

  // Architectural next-PC rule for one instruction at pc.
  task automatic ref_pred(input logic [63:0] pc, input ent_t e, output logic tk, output logic [63:0] npc);
    logic [63:0] base;
    tk  = 1'b0;
    npc = pc + 64'd4;
    case (e.kind)
      1: begin tk = 1'b1; npc = pc + e.imm; end
      2: if (e.imm < 0) begin tk = 1'b1; npc = pc + e.imm; end
      3: begin
        base = (e.rs1 == 0) ? 64'd0 : rf[e.rs1];
        tk   = 1'b1;
        npc  = (base + e.imm) & ~64'd1;
      end
      default: ;
    endcase
  endtask

  // ---------------------------------------------------------------- driver
  // Called at posedge+1: checks what the last edge produced, drives inputs for
  // the coming edge, advances the reference model, then steps one cycle.
  // mode 0: zero-wait memory, ID always ready; 1: random; 2: drain before reset
  task automatic step(input int mode);
    logic        flush;
    logic [63:0] fpc;
    logic        rdy;
    logic        idr;
    logic        deliver;
    logic        busy;
    logic        tk;
    logic [63:0] npc;
    ent_t        e;
    int          n;

    check_eq("if_valid", {63'd0, if_valid}, {63'd0, exp_valid});
    if (hold_chk) begin
      check_eq("req_hold_valid", {63'd0, ifu_req_valid}, 64'd1);
      check_eq("req_hold_pc", ifu_req_pc, hold_pc);
    end
    if (outstanding) check_eq("no_req_in_flight", {63'd0, ifu_req_valid}, 64'd0);

    flush = (mode == 1) && ($urandom_range(0, 19) == 0);
    fpc   = ($urandom_range(0, 3) == 0) ? 64'h8000_2000
                                         : 64'h8000_2000 + 64'($urandom_range(0, 1023)) * 64'd4;
    rdy   = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
    idr   = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;

    deliver = outstanding && (rsp_delay == 0);
    if (outstanding && rsp_delay > 0) rsp_delay--;

    busy = 1'b0;
    if (deliver && !killed) begin
      e = mem[out_addr];
      if (e.kind == 3) begin
        if (out_addr == JALR_PC) begin
          n        = 4;
          jalr_new = 64'h8000_1000;
        end else begin
          n        = $urandom_range(0, 4);
          jalr_new = {$urandom(), $urandom()};
        end
        if (n > 0) begin
          busy      = 1'b1;
          busy_left = n - 1;
          jalr_pend = 1'b1;
          jalr_rs1  = e.rs1;
        end
      end
    end else if (jalr_pend) begin
      if (busy_left > 0) begin
        busy = 1'b1;
        busy_left--;
      end else begin
        // Writeback completes as busy drops: the new value is visible now.
        jalr_pend = 1'b0;
        if (jalr_rs1 != 0) rf[jalr_rs1] = jalr_new;
      end
    end

    ifu_req_ready = rdy;
    id_ready      = idr;
    ex_flush      = flush;
    ex_flush_pc   = fpc;
    rs1_busy      = busy;
    ifu_rsp_valid = deliver;
    ifu_rsp_instr = deliver ? mem[out_addr].instr : $urandom();

    // ID acceptance of the presented instruction
    if (if_valid && idr && !flush && inst_pending) begin
      e = mem[pend_pc];
      ref_pred(pend_pc, e, tk, npc);
      check_eq("if_pc", if_pc, pend_pc);
      check_eq("if_instr", {32'd0, if_instr}, {32'd0, e.instr});
      check_eq("pred_taken", {63'd0, if_pred_taken}, {63'd0, tk});
      check_eq("pred_pc", if_pred_pc, npc);
      exp_q.push_back(npc);
      inst_pending = 1'b0;
      n_id_acc++;
    end

    if (deliver) begin
      outstanding = 1'b0;
      if (!killed && !flush) begin
        inst_pending = 1'b1;
        pend_pc      = out_pc;
      end
    end

    if (ifu_req_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check_eq("req_unexpected", ifu_req_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        out_pc = ifu_req_pc;
      end else begin
        out_pc = exp_q.pop_front();
        check_eq("req_pc", ifu_req_pc, out_pc);
      end
      out_addr    = ifu_req_pc;
      outstanding = 1'b1;
      killed      = flush;
      rsp_delay   = (mode == 0) ? 0 : (mode == 2) ? 2 : $urandom_range(0, 2);
      ensure_ent(out_addr);
    end

    if (flush) begin
      exp_q.delete();
      exp_q.push_back(fpc);
      inst_pending = 1'b0;
      jalr_pend    = 1'b0;
      busy_left    = 0;
      if (outstanding) killed = 1'b1;
    end

    exp_valid = inst_pending && !busy;
    hold_chk  = ifu_req_valid && !rdy && !flush;
    hold_pc   = ifu_req_pc;

    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    n_checks      = 0;
    n_pass        = 0;
    n_id_acc      = 0;
    exp_valid     = 1'b0;
    outstanding   = 1'b0;
    killed        = 1'b0;
    out_addr      = '0;
    out_pc        = '0;
    rsp_delay     = 0;
    inst_pending  = 1'b0;
    pend_pc       = '0;
    jalr_pend     = 1'b0;
    busy_left     = 0;
    jalr_rs1      = 0;
    jalr_new      = '0;
    hold_chk      = 1'b0;
    hold_pc       = '0;
    exp_q.push_back(RESET_PC);

    rf[0] = 64'd0;
    for (int i = 1; i < 32; i++) rf[i] = 64'h8000_0000 + 64'($urandom_range(0, 65535)) * 64'd2;
    rf[5] = 64'h0000_1234;

    // Directed opening sequence, then random code wherever control lands.
    put_ent(64'h8000_0000, 0, 0, 0);     // ADDI
    put_ent(64'h8000_0004, 1, 12, 0);    // JAL +0xC   -> 0x8000_0010
    put_ent(64'h8000_0010, 2, -8, 0);    // BEQ -8     -> taken 0x8000_0008
    put_ent(64'h8000_0008, 2, 8, 0);     // BEQ +8     -> not taken 0x8000_000C
    put_ent(JALR_PC, 3, 3, 5);           // JALR x5,3  -> 0x8000_1002 after busy

    rst_n         = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_instr = '0;
    rs1_busy      = 1'b0;
    id_ready      = 1'b0;
    ex_flush      = 1'b0;
    ex_flush_pc   = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_valid", {63'd0, ifu_req_valid}, 64'd0);
    check_eq("rst_req_pc", ifu_req_pc, RESET_PC);
    check_eq("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check_eq("rst_if_instr", {32'd0, if_instr}, 64'd0);
    check_eq("rst_if_pc", if_pc, 64'd0);
    check_eq("rst_pred_taken", {63'd0, if_pred_taken}, 64'd0);
    check_eq("rst_pred_pc", if_pred_pc, 64'd0);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("first_req_valid", {63'd0, ifu_req_valid}, 64'd1);
    check_eq("first_req_pc", ifu_req_pc, RESET_PC);

    for (int c = 0; c < 40; c++) step(0);
    for (int c = 0; c < 3000; c++) step(1);
    check_eq("progress", {63'd0, n_id_acc > 100}, 64'd1);

    // Bring the FSM to WAIT with a fetch in flight, then reset mid-cycle.
    for (int c = 0; c < 40; c++) begin
      step(2);
      if (outstanding) break;
    end
    check_eq("reach_wait", {63'd0, outstanding}, 64'd1);
    ifu_rsp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req_valid", {63'd0, ifu_req_valid}, 64'd0);
    check_eq("arst_req_pc", ifu_req_pc, RESET_PC);
    check_eq("arst_if_valid", {63'd0, if_valid}, 64'd0);
    check_eq("arst_if_instr", {32'd0, if_instr}, 64'd0);
    check_eq("arst_if_pc", if_pc, 64'd0);
    check_eq("arst_pred_taken", {63'd0, if_pred_taken}, 64'd0);
    check_eq("arst_pred_pc", if_pred_pc, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
